rom_word_packer: RTL and testbench
==================================

// Module: rom_word_packer
// PURPOSE
//  Writer side of the program-RAM path: packs 2-bit RGBY colour symbols from the colour
//  detector into 12-bit instruction words and writes them sequentially into the RAM.
//  Sits between colour detection and the RAM; muxes the RAM address port between its
//  write pointer and the CPU fetch address (the CPU is halted while the cartridge loads).
// PARAMETERS
//  SYM_W          2    bits per colour symbol
//  SYMS_PER_WORD  6    symbols per RAM word (word width = SYM_W*SYMS_PER_WORD = 12)
//  ADDR_W         8    RAM address width
//  WORD_LIMIT     256  words accepted before FULL (1..2**ADDR_W)
// PORTS
//  clk          in   1       system clock (1 MHz domain)
//  reset        in   1       asynchronous, active-low
//  start        in   1       1-cycle pulse: clear pointer/partial word, begin load
//  color_valid  in   1       1-cycle pulse: color is a valid detected symbol
//  color        in   SYM_W   00=R 01=G 10=B 11=Y
//  flush        in   1       1-cycle pulse: write partial word, zero-padded at LSBs
//  rd_addr      in   ADDR_W  CPU fetch address
//  ram_addr     out  ADDR_W  RAM address: wr_ptr when ram_we=1, else rd_addr (combinational)
//  ram_din      out  12      word being written (registered)
//  ram_we       out  1       RAM write strobe, exactly 1 cycle per word
//  word_count   out  ADDR_W+1  words written since start
//  busy         out  1       1 in COLLECT/WRITE
//  full         out  1       1 in FULL
//  overflow     out  1       sticky: symbol or flush data dropped in FULL
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; ram_we=0, ram_din=0, word_count=0, busy=0,
//  full=0, overflow=0, sym_cnt=0, shift=0, wr_ptr=0. Outputs valid the cycle reset deasserts.
//  Packing: first symbol lands in MSBs; shift <= {shift[9:0], color}. On the
//  SYMS_PER_WORD-th symbol: word_q <= {shift[9:0],color}, shift<=0, sym_cnt<=0 -> WRITE.
//  word_q is separate from shift, so symbols arriving during WRITE are accepted normally.
//  States:
//   IDLE    : ignore color_valid/flush; start -> COLLECT (sym_cnt=0, wr_ptr=0, count=0, overflow=0).
//   COLLECT : accept symbols; word complete -> WRITE. flush with sym_cnt>0 ->
//             word_q = shift << SYM_W*(SYMS_PER_WORD-sym_cnt) -> WRITE; flush with sym_cnt=0 no-op.
//   WRITE   : 1 cycle: ram_we=1, ram_din=word_q, ram_addr=wr_ptr; next cycle wr_ptr++,
//             word_count++; -> FULL if word_count+1==WORD_LIMIT else COLLECT.
//   FULL    : ram_we=0; color_valid or flush(sym_cnt>0) sets overflow; start -> restart.
//  Latency: ram_we asserts the cycle after the completing color_valid (or flush).
//  Simultaneous events:
//   - color_valid+flush same cycle: symbol shifted in first, then flush pads the result;
//     if that symbol completes the word, flush adds nothing.
//   - start wins over everything: discards partial word, no write in that cycle.
//   - word completes in WRITE cycle (SYMS_PER_WORD=1 only): cannot occur at default; assert.
//   - wr_ptr wraps only if WORD_LIMIT=2**ADDR_W, and FULL is entered first.
//  Width: word_count is ADDR_W+1 bits so WORD_LIMIT=256 is representable.
// STRUCTURE
//  Shared package/header: colour codes (COLOR_RED=2'b00, COLOR_GREEN=2'b01,
//  COLOR_BLUE=2'b10, COLOR_YELLOW=2'b11), WORD_W=12, state encodings.
//  Single module; no sub-module needed (shift/packing logic is inline).
// TESTING
//  1 start; R,G,B,Y,R,G -> one ram_we at addr 0, ram_din=12'h1B1, word_count=1, busy=1.
//  2 then Y x6, each with a 3-cycle gap -> ram_we at addr 1, ram_din=12'hFFF, word_count=2.
//  3 start; B,Y then flush -> ram_we at addr 0, ram_din=12'hB00; sym_cnt back to 0.
//  4 WORD_LIMIT=2: 12 symbols -> 2 writes, full=1; 1 more symbol -> overflow=1, no ram_we.
//  5 start; 4 symbols; reset low for 1 cycle mid-collect -> all outputs at reset values,
//    state IDLE; later color_valid without start -> no write.
//  6 IDLE with rd_addr=8'h2A -> ram_addr=8'h2A; during write to wr_ptr=3 -> ram_addr=8'h03.

Source files
------------

// File: rtl/rom_word_packer_pkg.sv
// rtl/rom_word_packer_pkg.sv - shared colour codes, word width and FSM encodings for the ROM word packer
package rom_word_packer_pkg;

    localparam int WORD_W = 12;

    localparam logic [1:0] COLOR_RED    = 2'b00;
    localparam logic [1:0] COLOR_GREEN  = 2'b01;
    localparam logic [1:0] COLOR_BLUE   = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

endpackage

// File: rtl/rom_word_packer.sv
// rtl/rom_word_packer.sv - packs colour symbols into RAM words and muxes the RAM address with CPU fetch
module rom_word_packer
    import rom_word_packer_pkg::*;
#(
    parameter int SYM_W         = 2,
    parameter int SYMS_PER_WORD = 6,
    parameter int ADDR_W        = 8,
    parameter int WORD_LIMIT    = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             color_valid,
    input  logic [SYM_W-1:0]                 color,
    input  logic                             flush,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic [ADDR_W-1:0]                ram_addr,
    output logic [SYM_W*SYMS_PER_WORD-1:0]   ram_din,
    output logic                             ram_we,
    output logic [ADDR_W:0]                  word_count,
    output logic                             busy,
    output logic                             full,
    output logic                             overflow
);

    localparam int WW = SYM_W * SYMS_PER_WORD;
    localparam int CW = $clog2(SYMS_PER_WORD + 1);
    localparam logic [CW-1:0]   SPW   = CW'(SYMS_PER_WORD);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(WORD_LIMIT);

    state_t            state;
    logic [WW-1:0]     shift;
    logic [CW-1:0]     sym_cnt;
    logic [ADDR_W-1:0] wr_ptr;

    logic [WW-1:0]     shift_in;
    logic [CW-1:0]     cnt_in;
    logic              word_done;
    logic [WW-1:0]     padded;

    // Shift register contents after this cycle's symbol, so flush pads the combined result
    always_comb begin
        shift_in = shift;
        cnt_in   = sym_cnt;
        if (color_valid) begin
            shift_in = (shift << SYM_W) | WW'(color);
            cnt_in   = sym_cnt + 1'b1;
        end
        word_done = color_valid && (cnt_in == SPW);
        padded    = shift_in << (SYM_W * (SYMS_PER_WORD - int'(cnt_in)));
    end

    assign ram_addr = ram_we ? wr_ptr : rd_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            sym_cnt    <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
        end else begin
            ram_we <= 1'b0;
            if (start) begin
                state      <= ST_COLLECT;
                shift      <= '0;
                sym_cnt    <= '0;
                wr_ptr     <= '0;
                word_count <= '0;
                overflow   <= 1'b0;
                busy       <= 1'b1;
                full       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_COLLECT: begin
                        if (word_done || (flush && cnt_in != '0)) begin
                            ram_din <= word_done ? shift_in : padded;
                            ram_we  <= 1'b1;
                            shift   <= '0;
                            sym_cnt <= '0;
                            state   <= ST_WRITE;
                        end else begin
                            shift   <= shift_in;
                            sym_cnt <= cnt_in;
                        end
                    end
                    ST_WRITE: begin
                        // word_q lives in ram_din, so the shift register keeps accepting symbols
                        shift      <= shift_in;
                        sym_cnt    <= cnt_in;
                        wr_ptr     <= wr_ptr + 1'b1;
                        word_count <= word_count + 1'b1;
                        if (word_count + 1'b1 == LIMIT) begin
                            state <= ST_FULL;
                            busy  <= 1'b0;
                            full  <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                    ST_FULL: begin
                        if (color_valid || (flush && sym_cnt != '0))
                            overflow <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !start && state == ST_WRITE)
            assert (!word_done) else $error("word completed during WRITE cycle");
    end

endmodule

// File: tb/tb_rom_word_packer.sv
// tb/tb_rom_word_packer.sv - directed self-checking bench for rom_word_packer
module tb_rom_word_packer;
    import rom_word_packer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, color_valid, flush;
    logic [1:0] color;
    logic [7:0] rd_addr;

    logic [7:0]  addr0, addr1;
    logic [11:0] din0, din1;
    logic        we0, we1, busy0, busy1, full0, full1, ovf0, ovf1;
    logic [8:0]  cnt0, cnt1;

    int compared   = 0;
    int mismatched = 0;
    int we_cnt0    = 0;
    int we_cnt1    = 0;
    int base;

    always #5 clk = ~clk;

    rom_word_packer u0 (
        .clk(clk), .reset(reset), .start(start), .color_valid(color_valid), .color(color),
        .flush(flush), .rd_addr(rd_addr), .ram_addr(addr0), .ram_din(din0), .ram_we(we0),
        .word_count(cnt0), .busy(busy0), .full(full0), .overflow(ovf0)
    );

    rom_word_packer #(.WORD_LIMIT(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .color_valid(color_valid), .color(color),
        .flush(flush), .rd_addr(rd_addr), .ram_addr(addr1), .ram_din(din1), .ram_we(we1),
        .word_count(cnt1), .busy(busy1), .full(full1), .overflow(ovf1)
    );

    always @(negedge clk) begin
        if (we0) we_cnt0++;
        if (we1) we_cnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] c);
        color       = c;
        color_valid = 1'b1;
        tick();
        color_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; color_valid = 1'b0; flush = 1'b0;
        color = 2'b00; rd_addr = 8'h11;
        #1;
        chk("rst_we",       32'(we0),   32'd0);
        chk("rst_din",      32'(din0),  32'h0);
        chk("rst_count",    32'(cnt0),  32'd0);
        chk("rst_busy",     32'(busy0), 32'd0);
        chk("rst_full",     32'(full0), 32'd0);
        chk("rst_overflow", 32'(ovf0),  32'd0);
        chk("rst_addr",     32'(addr0), 32'h11);
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: R,G,B,Y,R,G -> 12'h1B1 at address 0
        pulse_start();
        chk("t1_busy", 32'(busy0), 32'd1);
        base = we_cnt0;
        sym(COLOR_RED); sym(COLOR_GREEN); sym(COLOR_BLUE); sym(COLOR_YELLOW); sym(COLOR_RED);
        chk("t1_no_early_we", 32'(we_cnt0 - base), 32'd0);
        sym(COLOR_GREEN);
        chk("t1_we",   32'(we0),   32'd1);
        chk("t1_addr", 32'(addr0), 32'h00);
        chk("t1_din",  32'(din0),  32'h1B1);
        tick();
        chk("t1_we_off", 32'(we0),   32'd0);
        chk("t1_count",  32'(cnt0),  32'd1);
        chk("t1_busy2",  32'(busy0), 32'd1);
        chk("t1_writes", 32'(we_cnt0 - base), 32'd1);

        // 2: Y x6 with 3-cycle gaps -> 12'hFFF at address 1
        for (int i = 0; i < 6; i++) begin
            sym(COLOR_YELLOW);
            if (i < 5) begin
                chk("t2_no_we", 32'(we0), 32'd0);
                repeat (3) tick();
            end
        end
        chk("t2_we",   32'(we0),   32'd1);
        chk("t2_addr", 32'(addr0), 32'h01);
        chk("t2_din",  32'(din0),  32'hFFF);
        tick();
        chk("t2_count", 32'(cnt0), 32'd2);

        // 6a: address mux shows rd_addr while not writing, wr_ptr=3 while writing
        rd_addr = 8'h2A;
        #1;
        chk("t6_addr_rd", 32'(addr0), 32'h2A);
        for (int i = 0; i < 12; i++) sym(COLOR_RED);
        chk("t6_we",       32'(we0),   32'd1);
        chk("t6_addr_wr3", 32'(addr0), 32'h03);
        tick();
        chk("t6_count", 32'(cnt0), 32'd4);
        chk("t6_addr_back", 32'(addr0), 32'h2A);

        // 3: B,Y then flush -> zero-padded 12'hB00
        pulse_start();
        sym(COLOR_BLUE); sym(COLOR_YELLOW);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_we",     32'(we0),       32'd1);
        chk("t3_addr",   32'(addr0),     32'h00);
        chk("t3_din",    32'(din0),      32'hB00);
        chk("t3_symcnt", 32'(u0.sym_cnt), 32'd0);
        tick();
        chk("t3_count", 32'(cnt0), 32'd1);
        base = we_cnt0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t3_empty_flush", 32'(we_cnt0 - base), 32'd0);

        // symbol and flush together: symbol enters first, then padding
        sym(COLOR_BLUE);
        color = COLOR_GREEN; color_valid = 1'b1; flush = 1'b1;
        tick();
        color_valid = 1'b0; flush = 1'b0;
        chk("t3_cv_flush_we",  32'(we0),  32'd1);
        chk("t3_cv_flush_din", 32'(din0), 32'h900);
        tick();

        // 4: WORD_LIMIT=2 instance fills, then overflows
        pulse_start();
        chk("t4_start_clears_full", 32'(full1), 32'd0);
        base = we_cnt1;
        for (int i = 0; i < 12; i++) sym(COLOR_GREEN);
        chk("t4_we2",  32'(we1),  32'd1);
        chk("t4_din2", 32'(din1), 32'h555);
        chk("t4_addr2", 32'(addr1), 32'h01);
        tick();
        chk("t4_writes", 32'(we_cnt1 - base), 32'd2);
        chk("t4_full",   32'(full1), 32'd1);
        chk("t4_busy",   32'(busy1), 32'd0);
        chk("t4_count",  32'(cnt1),  32'd2);
        chk("t4_no_ovf", 32'(ovf1),  32'd0);
        sym(COLOR_RED);
        chk("t4_ovf",     32'(ovf1), 32'd1);
        chk("t4_ovf_nowe", 32'(we1), 32'd0);
        tick();
        chk("t4_ovf_sticky", 32'(ovf1), 32'd1);
        chk("t4_no_extra_we", 32'(we_cnt1 - base), 32'd2);
        pulse_start();
        chk("t4_restart_ovf",  32'(ovf1),  32'd0);
        chk("t4_restart_busy", 32'(busy1), 32'd1);

        // 5: asynchronous reset mid-collect, then symbols without start are ignored
        pulse_start();
        sym(COLOR_RED); sym(COLOR_GREEN); sym(COLOR_BLUE); sym(COLOR_YELLOW);
        reset = 1'b0;
        #1;
        chk("t5_busy",   32'(busy0),      32'd0);
        chk("t5_count",  32'(cnt0),       32'd0);
        chk("t5_din",    32'(din0),       32'h0);
        chk("t5_symcnt", 32'(u0.sym_cnt), 32'd0);
        chk("t5_state",  32'(u0.state),   32'(ST_IDLE));
        tick();
        reset = 1'b1;
        tick();
        base = we_cnt0;
        for (int i = 0; i < 6; i++) sym(COLOR_YELLOW);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t5_idle_no_write", 32'(we_cnt0 - base), 32'd0);
        chk("t5_idle_count",    32'(cnt0),  32'd0);
        chk("t5_idle_busy",     32'(busy0), 32'd0);

        // 6b: IDLE passes rd_addr through
        chk("t6_idle_addr", 32'(addr0), 32'h2A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
